// File: rtl/wb_master_seq.sv
// Wishbone initiator: converts single-transaction commands into Wishbone
// read/write cycles, one outstanding at a time, with a bus timeout and a
// saturating timeout counter. All Wishbone outputs come straight from flops.
module wb_master_seq #(
  parameter int                      ADDRWIDTH      = 10,
  parameter int                      DATAWIDTH      = 32,
  parameter int                      TIMEOUT_CYCLES = 16,
  parameter logic [DATAWIDTH-1:0]    ERR_DATA       = 32'hDEAD_BEEF
) (
  input  logic                 WBs_CLK_i,
  input  logic                 WBs_RST_n_i,
  // command side
  input  logic                 cmd_valid_i,
  output logic                 cmd_ready_o,
  input  logic                 cmd_we_i,
  input  logic [ADDRWIDTH-1:0] cmd_adr_i,
  input  logic [DATAWIDTH-1:0] cmd_dat_i,
  input  logic [3:0]           cmd_stb_i,
  // response side
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic [DATAWIDTH-1:0] rsp_dat_o,
  output logic                 rsp_err_o,
  output logic                 busy_o,
  output logic [7:0]           err_cnt_o,
  // Wishbone master
  output logic [ADDRWIDTH-1:0] WBm_ADR_o,
  output logic                 WBm_CYC_o,
  output logic                 WBm_STB_o,
  output logic                 WBm_WE_o,
  output logic [3:0]           WBm_BYTE_STB_o,
  output logic [DATAWIDTH-1:0] WBm_DAT_o,
  input  logic [DATAWIDTH-1:0] WBm_DAT_i,
  input  logic                 WBm_ACK_i
);

  typedef enum logic [1:0] {S_IDLE, S_BUS, S_RESP} state_t;

  // Counter reaches this value on the last STB cycle before abort.
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t                 r_state;
  logic [7:0]             r_tmo_cnt;
  logic [ADDRWIDTH-1:0]   r_adr;
  logic                   r_cyc;
  logic                   r_stb;
  logic                   r_we;
  logic [3:0]             r_bstb;
  logic [DATAWIDTH-1:0]   r_dat;
  logic                   r_rsp_valid;
  logic [DATAWIDTH-1:0]   r_rsp_dat;
  logic                   r_rsp_err;
  logic [7:0]             r_err_cnt;

  // Ready and busy are pure functions of the state.
  assign cmd_ready_o    = (r_state == S_IDLE);
  assign busy_o         = (r_state != S_IDLE);

  assign rsp_valid_o    = r_rsp_valid;
  assign rsp_dat_o      = r_rsp_dat;
  assign rsp_err_o      = r_rsp_err;
  assign err_cnt_o      = r_err_cnt;
  assign WBm_ADR_o      = r_adr;
  assign WBm_CYC_o      = r_cyc;
  assign WBm_STB_o      = r_stb;
  assign WBm_WE_o       = r_we;
  assign WBm_BYTE_STB_o = r_bstb;
  assign WBm_DAT_o      = r_dat;

  // Transaction FSM: accept in IDLE, drive the bus until ACK or timeout,
  // then hold the response until the requester takes it.
  always_ff @(posedge WBs_CLK_i or negedge WBs_RST_n_i) begin
    if (!WBs_RST_n_i) begin
      r_state     <= S_IDLE;
      r_tmo_cnt   <= '0;
      r_adr       <= '0;
      r_cyc       <= 1'b0;
      r_stb       <= 1'b0;
      r_we        <= 1'b0;
      r_bstb      <= '0;
      r_dat       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_dat   <= '0;
      r_rsp_err   <= 1'b0;
      r_err_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (cmd_valid_i) begin
            r_adr     <= cmd_adr_i;
            r_we      <= cmd_we_i;
            // Reads put zero on the write-data bus.
            r_dat     <= cmd_we_i ? cmd_dat_i : '0;
            r_bstb    <= cmd_stb_i;
            r_cyc     <= 1'b1;
            r_stb     <= 1'b1;
            r_tmo_cnt <= '0;
            r_state   <= S_BUS;
          end
        end
        S_BUS: begin
          // ACK takes priority over a timeout landing in the same cycle.
          if (WBm_ACK_i) begin
            r_rsp_dat   <= r_we ? '0 : WBm_DAT_i;
            r_rsp_err   <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_cyc       <= 1'b0;
            r_stb       <= 1'b0;
            r_state     <= S_RESP;
          end else if (r_tmo_cnt == TMO_LAST) begin
            r_rsp_dat   <= r_we ? '0 : ERR_DATA;
            r_rsp_err   <= 1'b1;
            r_rsp_valid <= 1'b1;
            r_cyc       <= 1'b0;
            r_stb       <= 1'b0;
            if (r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
            r_state     <= S_RESP;
          end else begin
            r_tmo_cnt   <= r_tmo_cnt + 8'd1;
          end
        end
        S_RESP: begin
          if (rsp_ready_i) begin
            r_rsp_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_master_seq.sv
// Testbench for wb_master_seq: directed and randomized transactions against
// a slave whose ACK timing is chosen per transaction, checked against a
// transaction-level model (STB length, response data/error, timeout count).
module tb_wb_master_seq;

  localparam int AW  = 10;
  localparam int DW  = 32;
  localparam int TMO = 16;
  localparam logic [31:0] ERRD = 32'hDEAD_BEEF;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid, cmd_ready, cmd_we;
  logic [AW-1:0] cmd_adr;
  logic [DW-1:0] cmd_dat;
  logic [3:0]    cmd_stb;
  logic          rsp_valid, rsp_ready, rsp_err, busy;
  logic [DW-1:0] rsp_dat;
  logic [7:0]    err_cnt;
  logic [AW-1:0] wb_adr;
  logic          wb_cyc, wb_stb, wb_we, wb_ack;
  logic [3:0]    wb_bstb;
  logic [DW-1:0] wb_dat_o, wb_dat_i;

  int n_cmp = 0;
  int n_mis = 0;
  int m_err = 0;   // model of the saturating timeout count

  always #5 clk = ~clk;

  wb_master_seq #(.ADDRWIDTH(AW), .DATAWIDTH(DW), .TIMEOUT_CYCLES(TMO), .ERR_DATA(ERRD)) dut (
    .WBs_CLK_i(clk), .WBs_RST_n_i(rst_n),
    .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_we_i(cmd_we),
    .cmd_adr_i(cmd_adr), .cmd_dat_i(cmd_dat), .cmd_stb_i(cmd_stb),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_dat_o(rsp_dat),
    .rsp_err_o(rsp_err), .busy_o(busy), .err_cnt_o(err_cnt),
    .WBm_ADR_o(wb_adr), .WBm_CYC_o(wb_cyc), .WBm_STB_o(wb_stb), .WBm_WE_o(wb_we),
    .WBm_BYTE_STB_o(wb_bstb), .WBm_DAT_o(wb_dat_o), .WBm_DAT_i(wb_dat_i),
    .WBm_ACK_i(wb_ack)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One full transaction. ack_at = STB cycle on which the slave ACKs
  // (0 = never). hold = cycles rsp_ready stays low while junk commands and
  // stray ACKs are presented. Entered and left at a negedge.
  task automatic do_txn(input logic we, input logic [AW-1:0] adr, input logic [DW-1:0] dat,
                        input logic [3:0] stb, input int ack_at, input logic [DW-1:0] sdat,
                        input int hold);
    int            len;
    bit            done;
    bit            tmo;
    logic [DW-1:0] exp_dato, exp_rsp;
    logic [33:0]   rsp_snap;
    tmo      = (ack_at == 0) || (ack_at > TMO);
    exp_dato = we ? dat : '0;
    exp_rsp  = we ? '0 : (tmo ? ERRD : sdat);
    cmd_valid = 1'b1; cmd_we = we; cmd_adr = adr; cmd_dat = dat; cmd_stb = stb;
    chk("ready_idle", cmd_ready, 1'b1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0; cmd_we = 1'($urandom); cmd_adr = AW'($urandom);
    cmd_dat = $urandom; cmd_stb = 4'($urandom);
    len = 0; done = 0;
    for (int c = 0; c < 40 && !done; c++) begin
      @(negedge clk);
      if (wb_stb) begin
        len++;
        chk("bus_fields", {wb_cyc, wb_we, wb_bstb, wb_adr, wb_dat_o},
                          {1'b1, we, stb, adr, exp_dato});
        wb_ack   = (len == ack_at);
        wb_dat_i = (len == ack_at) ? sdat : $urandom;
      end else begin
        wb_ack = 1'b0;
        done   = 1;
      end
    end
    chk("stb_dropped", 64'(done), 64'd1);
    chk("stb_len", 64'(len), 64'(tmo ? TMO : ack_at));
    if (tmo) m_err = (m_err == 255) ? 255 : m_err + 1;
    chk("rsp_valid", rsp_valid, 1'b1);
    chk("rsp_dat", rsp_dat, exp_rsp);
    chk("rsp_err", rsp_err, tmo);
    chk("err_cnt", err_cnt, 64'(m_err));
    chk("resp_bus", {cmd_ready, wb_cyc, wb_stb, busy}, 4'b0001);
    rsp_snap = {rsp_valid, rsp_err, rsp_dat};
    rsp_ready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      cmd_valid = 1'b1; cmd_we = 1'($urandom); cmd_adr = AW'($urandom); cmd_dat = $urandom;
      wb_ack = 1'($urandom); wb_dat_i = $urandom;
      @(negedge clk);
      chk("rsp_hold", {rsp_valid, rsp_err, rsp_dat}, rsp_snap);
      chk("hold_nobus", {cmd_ready, wb_cyc, wb_stb}, 3'b000);
    end
    wb_ack = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0; cmd_valid = 1'b0;
    @(negedge clk);
    chk("back_idle", {rsp_valid, cmd_ready, wb_cyc, busy}, 4'b0100);
  endtask

  initial begin
    rst_n = 1'b0; cmd_valid = 0; cmd_we = 0; cmd_adr = '0; cmd_dat = '0; cmd_stb = '0;
    rsp_ready = 0; wb_ack = 0; wb_dat_i = '0;
    @(negedge clk); @(negedge clk);
    chk("rst_ctl", {cmd_ready, rsp_valid, rsp_err, busy, wb_cyc, wb_stb, wb_we}, 7'b1000000);
    chk("rst_data", {rsp_dat, wb_dat_o}, 64'd0);
    chk("rst_misc", {err_cnt, wb_adr, wb_bstb}, 22'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // registered-ACK slave read, then write
    do_txn(1'b0, 10'h000, 32'h0, 4'hF, 2, 32'h0ADC_0001, 0);
    do_txn(1'b1, 10'h003, 32'hA5A5_5A5A, 4'hF, 2, 32'h1234_5678, 0);
    // no ACK -> timeout read, then write timeout
    do_txn(1'b0, 10'h155, 32'h0, 4'h3, 0, 32'h0, 0);
    do_txn(1'b1, 10'h2AA, 32'hCAFE_F00D, 4'h5, 0, 32'h0, 1);
    // ACK on the last STB cycle wins over timeout; ACK on the very first cycle
    do_txn(1'b0, 10'h011, 32'h0, 4'hF, TMO, 32'h7777_1111, 0);
    do_txn(1'b0, 10'h3FF, 32'h0, 4'h1, 1, 32'hFFFF_0000, 0);
    // response back-pressure with junk commands and stray ACKs
    do_txn(1'b0, 10'h0F0, 32'h0, 4'hC, 3, 32'h5555_AAAA, 5);
    do_txn(1'b1, 10'h00F, 32'h0BAD_CAFE, 4'h8, 2, 32'h0, 0);

    // randomized mix including late ACKs that time out
    for (int t = 0; t < 40; t++)
      do_txn(1'($urandom), AW'($urandom), $urandom, 4'($urandom),
             int'($urandom_range(0, 20)), $urandom, int'($urandom_range(0, 3)));

    // drive the timeout counter into saturation
    for (int t = 0; t < 260; t++)
      do_txn(1'($urandom), AW'($urandom), $urandom, 4'($urandom), 0, 32'h0, 0);
    chk("err_sat", err_cnt, 8'd255);

    // reset in the middle of a bus cycle
    cmd_valid = 1'b1; cmd_we = 1'b0; cmd_adr = 10'h123; cmd_stb = 4'hF;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_stb", {wb_cyc, wb_stb}, 2'b11);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst", {wb_cyc, wb_stb, rsp_valid, busy, cmd_ready}, 5'b00001);
    chk("async_rst_cnt", err_cnt, 8'd0);
    m_err = 0;
    @(negedge clk);
    rst_n = 1'b1;
    // stray ACKs in IDLE must do nothing
    for (int i = 0; i < 3; i++) begin
      wb_ack = 1'b1; wb_dat_i = $urandom;
      @(negedge clk);
      chk("stray_idle", {cmd_ready, busy, wb_cyc, wb_stb, rsp_valid}, 5'b10000);
    end
    wb_ack = 1'b0;
    chk("stray_rsp_dat", rsp_dat, 32'd0);
    do_txn(1'b1, 10'h042, 32'h1357_9BDF, 4'h6, 2, 32'h0, 0);
    do_txn(1'b0, 10'h043, 32'h0, 4'hF, 0, 32'h0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
